hamming_snapshot_checker: RTL and testbench

- Downstream consumer of the Hamming-protected counter output.
- On each idle entry (enable falling edge), it snapshots the counter and encodes per-nibble Hamming(7,4) parity.
- After a programmable hold window it re-reads the counter, computes the syndromes, corrects the value, and presents a report through a valid/ready handshake.
- It keeps a saturating count of reports with errors, for retention/SEU characterisation of the counter stage.

---
 rtl/hamming_pkg.sv | 21 ++
 rtl/hamming_block_decoder.sv | 30 +++
 rtl/hamming_snapshot_checker.sv | 143 ++++++++++++++
 tb/tb_hamming_snapshot_checker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and Hamming(7,4) helpers for the snapshot checker.
// Parity layout per nibble is {p2, p1, p0}.
package hamming_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    CHECK  = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam logic [2:0] SYN_D0 = 3'b111;
  localparam logic [2:0] SYN_D1 = 3'b011;
  localparam logic [2:0] SYN_D2 = 3'b101;
  localparam logic [2:0] SYN_D3 = 3'b110;

  function automatic logic [2:0] enc_nibble(input logic [3:0] d);
    return {d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d[0] ^ d[1] ^ d[2]};
  endfunction

endpackage

// File: rtl/hamming_block_decoder.sv
// Combinational Hamming(7,4) syndrome decode and single-bit correction for one nibble.
// Zero latency; no flow control.
module hamming_block_decoder
  import hamming_pkg::*;
(
  input  logic [3:0] data_i,
  input  logic [2:0] par_i,
  output logic [3:0] corrected_o,
  output logic       data_err_o,
  output logic       par_err_o
);

  logic [2:0] syn;

  always_comb begin
    syn         = par_i ^ enc_nibble(data_i);
    corrected_o = data_i;
    data_err_o  = 1'b0;
    par_err_o   = 1'b0;
    case (syn)
      SYN_D0: begin corrected_o[0] = ~data_i[0]; data_err_o = 1'b1; end
      SYN_D1: begin corrected_o[1] = ~data_i[1]; data_err_o = 1'b1; end
      SYN_D2: begin corrected_o[2] = ~data_i[2]; data_err_o = 1'b1; end
      SYN_D3: begin corrected_o[3] = ~data_i[3]; data_err_o = 1'b1; end
      3'b001, 3'b010, 3'b100: par_err_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hamming_snapshot_checker.sv
// Snapshots the counter on enable fall, re-checks it after a hold window and
// reports the corrected value over valid/ready; report held until accepted.
module hamming_snapshot_checker
  import hamming_pkg::*;
#(
  parameter int WIDTH       = 128,
  parameter int BLOCKS      = WIDTH / 4,
  parameter int PARITY_BITS = BLOCKS * 3,
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [WIDTH-1:0]       counter,
  input  logic [PARITY_BITS-1:0] inj_parity_mask,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_corrected,
  output logic [BLOCKS-1:0]      res_data_err_mask,
  output logic [BLOCKS-1:0]      res_par_err_mask,
  output logic                   res_mismatch,
  output logic [ERR_CNT_W-1:0]   err_count
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e                 state_q, state_d;
  logic                   enable_q;
  logic [WIDTH-1:0]       snap_q, snap_d;
  logic [PARITY_BITS-1:0] par_q, par_d;
  logic [HCW-1:0]         hold_cnt_q, hold_cnt_d;
  logic                   res_valid_q, res_valid_d;
  logic [WIDTH-1:0]       corr_q, corr_d;
  logic [BLOCKS-1:0]      dmask_q, dmask_d;
  logic [BLOCKS-1:0]      pmask_q, pmask_d;
  logic                   mismatch_q, mismatch_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic                   fall;
  logic [PARITY_BITS-1:0] enc_cur;
  logic [WIDTH-1:0]       corr_live;
  logic [BLOCKS-1:0]      derr_live, perr_live;

  assign fall = enable_q & ~enable;

  // Decoders always look at the live counter against the stored parity.
  for (genvar i = 0; i < BLOCKS; i++) begin : g_blk
    assign enc_cur[3*i +: 3] = enc_nibble(counter[4*i +: 4]);

    hamming_block_decoder u_dec (
      .data_i      (counter[4*i +: 4]),
      .par_i       (par_q[3*i +: 3]),
      .corrected_o (corr_live[4*i +: 4]),
      .data_err_o  (derr_live[i]),
      .par_err_o   (perr_live[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    par_d       = par_q;
    hold_cnt_d  = hold_cnt_q;
    res_valid_d = res_valid_q;
    corr_d      = corr_q;
    dmask_d     = dmask_q;
    pmask_d     = pmask_q;
    mismatch_d  = mismatch_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (fall) begin
          snap_d     = counter;
          par_d      = enc_cur ^ inj_parity_mask;
          hold_cnt_d = HCW'(HOLD_CYCLES - 1);
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (enable)                state_d    = IDLE;
        else if (hold_cnt_q == '0) state_d    = CHECK;
        else                       hold_cnt_d = hold_cnt_q - 1'b1;
      end
      CHECK: begin
        corr_d     = corr_live;
        dmask_d    = derr_live;
        pmask_d    = perr_live;
        mismatch_d = (corr_live != snap_q);
        // Every nonzero syndrome raises exactly one of the two per-block flags.
        if (((|derr_live) || (|perr_live)) && (err_cnt_q != '1))
          err_cnt_d = err_cnt_q + 1'b1;
        res_valid_d = 1'b1;
        state_d     = REPORT;
      end
      REPORT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      enable_q    <= 1'b0;
      snap_q      <= '0;
      par_q       <= '0;
      hold_cnt_q  <= '0;
      res_valid_q <= 1'b0;
      corr_q      <= '0;
      dmask_q     <= '0;
      pmask_q     <= '0;
      mismatch_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable;
      snap_q      <= snap_d;
      par_q       <= par_d;
      hold_cnt_q  <= hold_cnt_d;
      res_valid_q <= res_valid_d;
      corr_q      <= corr_d;
      dmask_q     <= dmask_d;
      pmask_q     <= pmask_d;
      mismatch_q  <= mismatch_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign busy              = (state_q != IDLE);
  assign res_valid         = res_valid_q;
  assign res_corrected     = corr_q;
  assign res_data_err_mask = dmask_q;
  assign res_par_err_mask  = pmask_q;
  assign res_mismatch      = mismatch_q;
  assign err_count         = err_cnt_q;

endmodule

// File: tb/tb_hamming_snapshot_checker.sv
// Scoreboard bench for hamming_snapshot_checker: expectations queued at stimulus,
// popped and compared when the report handshake completes.
module tb_hamming_snapshot_checker;

  localparam int W  = 16;
  localparam int B  = W / 4;
  localparam int PB = B * 3;
  localparam int HC = 4;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [W-1:0]  counter;
  logic [PB-1:0] inj_parity_mask;
  logic          busy;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_corrected;
  logic [B-1:0]  res_data_err_mask;
  logic [B-1:0]  res_par_err_mask;
  logic          res_mismatch;
  logic [EW-1:0] err_count;

  typedef struct {
    logic [W-1:0]  corr;
    logic [B-1:0]  dm;
    logic [B-1:0]  pm;
    logic          mm;
    logic [EW-1:0] ec;
  } exp_t;

  exp_t          sb_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [EW-1:0] exp_ec  = '0;

  always #5 clk = ~clk;

  hamming_snapshot_checker #(
    .WIDTH       (W),
    .HOLD_CYCLES (HC),
    .ERR_CNT_W   (EW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .counter           (counter),
    .inj_parity_mask   (inj_parity_mask),
    .busy              (busy),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_corrected     (res_corrected),
    .res_data_err_mask (res_data_err_mask),
    .res_par_err_mask  (res_par_err_mask),
    .res_mismatch      (res_mismatch),
    .err_count         (err_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] tb_enc(input logic [3:0] d);
    logic [2:0] p;
    p[2] = d[0] ^ d[2] ^ d[3];
    p[1] = d[0] ^ d[1] ^ d[3];
    p[0] = d[0] ^ d[1] ^ d[2];
    return p;
  endfunction

  // Reference decode by search: find the single data flip whose codeword matches
  // the stored parity; any other mismatch is a parity-bit error.
  task automatic push_expect(input logic [W-1:0] cap, input logic [W-1:0] live,
                             input logic [PB-1:0] inj);
    exp_t       e;
    logic [3:0] d, one;
    logic [2:0] p;
    logic       any, found;
    e.corr = live; e.dm = '0; e.pm = '0; any = 1'b0; one = 4'b0001;
    for (int b = 0; b < B; b++) begin
      d = live[4*b +: 4];
      p = tb_enc(cap[4*b +: 4]) ^ inj[3*b +: 3];
      if (tb_enc(d) != p) begin
        any = 1'b1; found = 1'b0;
        for (int j = 0; j < 4; j++) begin
          if (!found && tb_enc(d ^ (one << j)) == p) begin
            e.corr[4*b +: 4] = d ^ (one << j);
            e.dm[b] = 1'b1;
            found   = 1'b1;
          end
        end
        if (!found) e.pm[b] = 1'b1;
      end
    end
    e.mm = (e.corr != cap);
    if (any && exp_ec != 2'd3) exp_ec = exp_ec + 1'b1;
    e.ec = exp_ec;
    sb_q.push_back(e);
  endtask

  // Drives a capture, swaps in the live value during HOLD, then waits for the report.
  task automatic start_capture(input string tag, input logic [W-1:0] cap,
                               input logic [W-1:0] live, input logic [PB-1:0] inj,
                               input bit rdy, output int lat);
    @(negedge clk); enable = 1'b1; counter = cap; inj_parity_mask = inj; res_ready = rdy;
    @(negedge clk); enable = 1'b0;
    @(negedge clk); counter = live; inj_parity_mask = '0;
    check_eq({tag, "_busy"}, busy, 1'b1);
    push_expect(cap, live, inj);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, lat, HC + 1);
  endtask

  task automatic run_case(input string tag, input logic [W-1:0] cap, input logic [W-1:0] live,
                          input logic [PB-1:0] inj, input int delay, input bit toggle_en);
    int           lat;
    exp_t         e;
    logic [63:0]  held;
    bit           stable;
    start_capture(tag, cap, live, inj, (delay == 0), lat);
    if (delay > 0) begin
      held   = {res_corrected, res_data_err_mask, res_par_err_mask, res_mismatch, err_count};
      stable = 1'b1;
      for (int i = 0; i < delay; i++) begin
        if (toggle_en) enable = (i % 2 == 0) && (i < delay - 1);
        @(negedge clk);
        if (!res_valid || held != {res_corrected, res_data_err_mask, res_par_err_mask,
                                   res_mismatch, err_count}) stable = 1'b0;
      end
      check_eq({tag, "_stable"}, stable, 1'b1);
      res_ready = 1'b1;
    end
    e = sb_q.pop_front();
    check_eq({tag, "_corr"}, res_corrected, e.corr);
    check_eq({tag, "_dmask"}, res_data_err_mask, e.dm);
    check_eq({tag, "_pmask"}, res_par_err_mask, e.pm);
    check_eq({tag, "_mism"}, res_mismatch, e.mm);
    check_eq({tag, "_errcnt"}, err_count, e.ec);
    @(negedge clk); res_ready = 1'b0;
    check_eq({tag, "_vld_clr"}, res_valid, 1'b0);
    check_eq({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  saw_vld;
    rst = 1'b1; enable = 1'b0; counter = '0; inj_parity_mask = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_valid", res_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_outs", {res_corrected, res_data_err_mask, res_par_err_mask, res_mismatch}, '0);
    check_eq("rst_errcnt", err_count, '0);

    run_case("clean",  16'h0005, 16'h0005, 12'h000, 0, 1'b0);
    run_case("dflip",  16'h0005, 16'h0001, 12'h000, 2, 1'b0);
    run_case("pinj",   16'h1234, 16'h1234, 12'h010, 1, 1'b0);

    // Abort: enable rises during HOLD cycle 2.
    @(negedge clk); enable = 1'b1; counter = 16'hA5A5;
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); enable = 1'b1;
    @(negedge clk);
    check_eq("abort_idle", busy, 1'b0);
    saw_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid) saw_vld = 1'b1;
    end
    check_eq("abort_novld", saw_vld, 1'b0);

    run_case("bp",     16'hBEEF, 16'hBEEF, 12'h000, 10, 1'b1);
    run_case("dbl01",  16'h0005, 16'h0006, 12'h000, 1, 1'b0);
    run_case("dbl12",  16'h0005, 16'h0003, 12'h000, 1, 1'b0);
    run_case("sat",    16'h7777, 16'h7677, 12'h000, 1, 1'b0);

    // Reset while a report is pending drops it silently.
    start_capture("rstop", 16'h0005, 16'h0001, 12'h000, 1'b0, lat);
    check_eq("rstop_vld", res_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstop_vld_clr", res_valid, 1'b0);
    check_eq("rstop_busy", busy, 1'b0);
    check_eq("rstop_errcnt", err_count, '0);
    check_eq("rstop_corr", res_corrected, '0);
    rst = 1'b0;
    void'(sb_q.pop_front());
    exp_ec = '0;

    run_case("post",   16'hC3C3, 16'hC3C3, 12'h000, 0, 1'b0);
    check_eq("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
